// File: rtl/bcd_pkg.sv
// Shared types and sizing helpers for the binary-to-BCD converters.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } bcd_state_t;

    typedef logic [3:0] bcd_digit_t;

    // Decimal digits needed to hold any BITS-wide unsigned value (1233/4096 ~ log10(2)).
    function automatic int bcd_digits_for_bits(input int bits);
        return ((bits * 32'sd1233) >>> 5'd12) + 32'sd1;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the next shift.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  bcd_digit_t digit,
    output bcd_digit_t adjusted
);

    // add-3 correction so the following left shift carries into the next decade
    always_comb begin
        if (digit >= 4'd5) begin
            adjusted = digit + 4'd3;
        end else begin
            adjusted = digit;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter with start/done handshake and
// atomically updated display outputs (digits, decimal-point mask, overflow).
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int NUM_SEGMENTS = 8,
    parameter int BITS         = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [BITS-1:0]              bin_in,
    input  logic [NUM_SEGMENTS-1:0]      dp_in,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow,
    output logic [NUM_SEGMENTS-1:0][3:0] encoded,
    output logic [NUM_SEGMENTS-1:0]      decimal
);

    localparam int MIN_DIGITS = bcd_digits_for_bits(BITS);
    localparam int INT_DIGITS = (NUM_SEGMENTS > MIN_DIGITS) ? NUM_SEGMENTS : MIN_DIGITS;
    localparam int CNT_W      = $clog2(BITS + 1);
    localparam int CAT_W      = INT_DIGITS * 4 + BITS;

    bcd_state_t                      state_r;
    bcd_state_t                      state_nxt_s;
    logic [CNT_W-1:0]                bit_cnt_r;
    logic [BITS-1:0]                 shreg_r;
    bcd_digit_t [INT_DIGITS-1:0]     scratch_r;
    logic [NUM_SEGMENTS-1:0]         dp_hold_r;

    bcd_digit_t [INT_DIGITS-1:0]     adj_s;
    logic [CAT_W-1:0]                cat_s;
    bcd_digit_t [INT_DIGITS-1:0]     scratch_nxt_s;
    logic [BITS-1:0]                 shreg_nxt_s;
    logic                            last_shift_s;
    logic                            ovf_s;
    logic [NUM_SEGMENTS-1:0][3:0]    enc_nxt_s;

    logic                            busy_s;
    logic                            done_s;
    logic                            busy_r;
    logic                            done_r;
    logic                            overflow_r;
    logic [NUM_SEGMENTS-1:0][3:0]    encoded_r;
    logic [NUM_SEGMENTS-1:0]         decimal_r;

    genvar g;
    generate
        for (g = 0; g < INT_DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit    (scratch_r[g]),
                .adjusted (adj_s[g])
            );
        end
    endgenerate

    // one double-dabble step: corrected scratch and binary shift register move left as one word
    always_comb begin
        cat_s         = {adj_s, shreg_r} << 1'b1;
        scratch_nxt_s = cat_s[CAT_W-1:BITS];
        shreg_nxt_s   = cat_s[BITS-1:0];
        last_shift_s  = (bit_cnt_r == CNT_W'(1));
    end

    // result shaping: any nonzero digit beyond the display saturates to all nines
    always_comb begin
        ovf_s = 1'b0;
        for (int i = NUM_SEGMENTS; i < INT_DIGITS; i++) begin
            ovf_s = ovf_s | (scratch_nxt_s[i] != 4'd0);
        end
        if (ovf_s) begin
            enc_nxt_s = {NUM_SEGMENTS{4'h9}};
        end else begin
            enc_nxt_s = scratch_nxt_s[NUM_SEGMENTS-1:0];
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_shift_s) begin
                    state_nxt_s = FINISH;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            FINISH:  state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs, decoded from the next state so the registered flags line up with the state
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_nxt_s)
            IDLE: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
            SHIFT: begin
                busy_s = 1'b1;
                done_s = 1'b0;
            end
            FINISH: begin
                busy_s = 1'b1;
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // handshake flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_s;
            done_r <= done_s;
        end
    end

    // conversion datapath and display registers; results land on the edge entering FINISH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r  <= '0;
            shreg_r    <= '0;
            scratch_r  <= '0;
            dp_hold_r  <= '0;
            overflow_r <= 1'b0;
            encoded_r  <= '0;
            decimal_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        shreg_r   <= bin_in;
                        dp_hold_r <= dp_in;
                        scratch_r <= '0;
                        bit_cnt_r <= CNT_W'(BITS);
                    end
                end
                SHIFT: begin
                    scratch_r <= scratch_nxt_s;
                    shreg_r   <= shreg_nxt_s;
                    bit_cnt_r <= bit_cnt_r - CNT_W'(1);
                    if (last_shift_s) begin
                        encoded_r  <= enc_nxt_s;
                        overflow_r <= ovf_s;
                        decimal_r  <= dp_hold_r;
                    end
                end
                default: begin
                    bit_cnt_r <= bit_cnt_r;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign overflow = overflow_r;
    assign encoded  = encoded_r;
    assign decimal  = decimal_r;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: an 8-digit and a 4-digit instance share stimulus.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bin_in = 16'd0;
    logic [7:0]  dp_in = 8'd0;

    logic            busy8, done8, ovf8;
    logic [7:0][3:0] enc8;
    logic [7:0]      dec8;
    logic            busy4, done4, ovf4;
    logic [3:0][3:0] enc4;
    logic [3:0]      dec4;

    bin2bcd_seq #(.NUM_SEGMENTS(8), .BITS(16)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in), .dp_in(dp_in),
        .busy(busy8), .done(done8), .overflow(ovf8), .encoded(enc8), .decimal(dec8)
    );

    bin2bcd_seq #(.NUM_SEGMENTS(4), .BITS(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in), .dp_in(dp_in[3:0]),
        .busy(busy4), .done(done4), .overflow(ovf4), .encoded(enc4), .decimal(dec4)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] e8;
        logic [15:0] e4;
        logic        o4;
        logic [7:0]  dp;
        int          acc;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic [15:0] bin;
        logic [7:0]  dp;
        logic [31:0] e8;
        logic [15:0] e4;
        logic        o4;
    } vec_t;

    vec_t vecs[12] = '{
        '{16'd65535, 8'h04, 32'h00065535, 16'h9999, 1'b1},
        '{16'd0,     8'h00, 32'h00000000, 16'h0000, 1'b0},
        '{16'd9,     8'h81, 32'h00000009, 16'h0009, 1'b0},
        '{16'd10000, 8'hFF, 32'h00010000, 16'h9999, 1'b1},
        '{16'd9999,  8'h10, 32'h00009999, 16'h9999, 1'b0},
        '{16'd1234,  8'h02, 32'h00001234, 16'h1234, 1'b0},
        '{16'd5,     8'h20, 32'h00000005, 16'h0005, 1'b0},
        '{16'd32768, 8'h40, 32'h00032768, 16'h9999, 1'b1},
        '{16'd59999, 8'h08, 32'h00059999, 16'h9999, 1'b1},
        '{16'd100,   8'h01, 32'h00000100, 16'h0100, 1'b0},
        '{16'd4095,  8'h11, 32'h00004095, 16'h4095, 1'b0},
        '{16'd42,    8'h3C, 32'h00000042, 16'h0042, 1'b0}
    };

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // decimal reference by repeated division, saturating to nines when digits run out
    function automatic logic [31:0] ref_bcd(input int unsigned v, input int nd, output logic ovf);
        logic [31:0] r;
        int unsigned x;
        r = 32'd0;
        x = v;
        for (int i = 0; i < nd; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        ovf = (x != 0);
        if (ovf) begin
            for (int i = 0; i < nd; i++) r[i*4 +: 4] = 4'h9;
        end
        return r;
    endfunction

    // issue one conversion once the DUT is idle and queue its expected result
    task automatic issue(input logic [15:0] b, input logic [7:0] d,
                         input logic [31:0] e8, input logic [15:0] e4, input logic o4);
        exp_t e;
        int w;
        w = 0;
        while ((busy8 || done8) && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: DUT still busy after %0d cycles", w);
        end
        start  = 1'b1;
        bin_in = b;
        dp_in  = d;
        @(posedge clk);
        #1;
        e.e8 = e8; e.e4 = e4; e.o4 = o4; e.dp = d; e.acc = cyc;
        q.push_back(e);
        @(negedge clk);
        start  = 1'b0;
        bin_in = ~b;
        dp_in  = ~d;
        chk("busy_after_start", 64'(busy8), 64'd1);
        chk("no_early_done", 64'(done8), 64'd0);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (q.size() != 0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("queue_drained", 64'(q.size()), 64'd0);
    endtask

    logic [31:0] last8 = 32'd0;
    logic [15:0] last4 = 16'd0;
    logic        lasto4 = 1'b0;
    exp_t        mon_e;

    // monitor: pops the scoreboard on each done and checks outputs hold between results
    always @(negedge clk) begin
        if (!rst_n) begin
            last8  = 32'd0;
            last4  = 16'd0;
            lasto4 = 1'b0;
        end else begin
            chk("done_both", 64'(done4), 64'(done8));
            if (done8) begin
                chk("busy_with_done", 64'(busy8), 64'd1);
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending conversion (cycle %0d)", cyc);
                end else begin
                    mon_e = q.pop_front();
                    chk("latency", 64'(cyc - mon_e.acc), 64'd16);
                    chk("enc8", 64'(enc8), 64'(mon_e.e8));
                    chk("ovf8", 64'(ovf8), 64'd0);
                    chk("dec8", 64'(dec8), 64'(mon_e.dp));
                    chk("enc4", 64'(enc4), 64'(mon_e.e4));
                    chk("ovf4", 64'(ovf4), 64'(mon_e.o4));
                    chk("dec4", 64'(dec4), 64'(mon_e.dp[3:0]));
                    last8  = mon_e.e8;
                    last4  = mon_e.e4;
                    lasto4 = mon_e.o4;
                end
            end else begin
                chk("hold_enc8", 64'(enc8), 64'(last8));
                chk("hold_enc4", 64'(enc4), 64'(last4));
                chk("hold_ovf4", 64'(ovf4), 64'(lasto4));
            end
        end
    end

    initial begin
        exp_t        e;
        logic        o;
        logic [31:0] r8;
        logic [15:0] rb;

        #1;
        chk("rst_enc8", 64'(enc8), 64'd0);
        chk("rst_busy", 64'(busy8), 64'd0);
        chk("rst_done", 64'(done8), 64'd0);
        chk("rst_ovf", 64'(ovf8), 64'd0);
        chk("rst_dec8", 64'(dec8), 64'd0);
        #20 rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) issue(vecs[i].bin, vecs[i].dp, vecs[i].e8, vecs[i].e4, vecs[i].o4);
        drain();

        // reset in the middle of a conversion discards it
        issue(16'd1234, 8'h55, 32'h00001234, 16'h1234, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        #1;
        chk("midrst_enc8", 64'(enc8), 64'd0);
        chk("midrst_enc4", 64'(enc4), 64'd0);
        chk("midrst_dec8", 64'(dec8), 64'd0);
        chk("midrst_busy", 64'(busy8), 64'd0);
        chk("midrst_done", 64'(done8), 64'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (25) @(negedge clk);
        chk("post_rst_idle", 64'(busy8), 64'd0);

        // start held high: accepted every 18 cycles with the bin_in present at acceptance
        for (int c = 0; c < 72; c++) begin
            start  = 1'b1;
            bin_in = 16'(c * 2731 + 17);
            dp_in  = 8'(c * 5);
            @(posedge clk);
            #1;
            if (c % 18 == 0) begin
                e.e8 = ref_bcd(32'(bin_in), 8, o);
                r8   = ref_bcd(32'(bin_in), 4, o);
                e.e4 = r8[15:0];
                e.o4 = o;
                e.dp = dp_in;
                e.acc = cyc;
                q.push_back(e);
            end
            @(negedge clk);
        end
        start = 1'b0;
        drain();

        for (int k = 0; k < 150; k++) begin
            rb = 16'($urandom_range(0, 65535));
            r8 = ref_bcd(32'(rb), 4, o);
            issue(rb, 8'($urandom_range(0, 255)), ref_bcd(32'(rb), 8, e.o4), r8[15:0], o);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
